// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants: opcodes, immediate formats and the
// opcode-to-immediate-format mapping used by the decode stage.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    // R-type and unknown opcodes carry no immediate.
    function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
        case (opc)
            OPC_OPIMM, OPC_LOAD, OPC_JALR: return IMM_I;
            OPC_STORE:                     return IMM_S;
            OPC_BRANCH:                    return IMM_B;
            OPC_LUI, OPC_AUIPC:            return IMM_U;
            OPC_JAL:                       return IMM_J;
            default:                       return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: IF/ID input, register-file read port, write-back bypass,
// pipeline control and the ID/EX register outputs.
interface id_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [PC_W-1:0] if_pc;
    logic            id_ready;
    logic [4:0]      rf_rs1;
    logic [4:0]      rf_rs2;
    logic [XLEN-1:0] rf_rs1_data;
    logic [XLEN-1:0] rf_rs2_data;
    logic            wb_regwrite;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ex_stall;
    logic            flush;
    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_imm;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            ex_memwrite;

    modport master (
        output if_valid, if_instr, if_pc, rf_rs1_data, rf_rs2_data,
               wb_regwrite, wb_rd, wb_data, ex_stall, flush,
        input  id_ready, rf_rs1, rf_rs2, ex_valid, ex_pc, ex_rs1_data,
               ex_rs2_data, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_opcode,
               ex_funct3, ex_funct7b5, ex_regwrite, ex_memread, ex_memwrite
    );

    modport slave (
        input  if_valid, if_instr, if_pc, rf_rs1_data, rf_rs2_data,
               wb_regwrite, wb_rd, wb_data, ex_stall, flush,
        output id_ready, rf_rs1, rf_rs2, ex_valid, ex_pc, ex_rs1_data,
               ex_rs2_data, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_opcode,
               ex_funct3, ex_funct7b5, ex_regwrite, ex_memread, ex_memwrite
    );
endinterface

// File: rtl/imm_gen.sv
// Combinational immediate generator: selects the I/S/B/U/J layout from the
// opcode and sign-extends it to XLEN.
module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm
);
    imm_fmt_e    w_fmt;
    logic [31:0] w_imm;

    assign w_fmt = imm_fmt(i_instr[6:0]);

    always_comb begin
        w_imm = '0;
        case (w_fmt)
            IMM_I: w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S: w_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B: w_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U: w_imm = {i_instr[31:12], 12'b0};
            IMM_J: w_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                            i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm));

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register read with write-back bypass, immediate
// generation, load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
    parameter int XLEN = rv32_pkg::XLEN,
    parameter int PC_W = 32
) (
    input logic       clk,
    input logic       rst_n,
    id_stage_if.slave bus
);
    import rv32_pkg::*;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic            w_rs1_used, w_rs2_used, w_rw_raw, w_memread, w_memwrite;
    logic            w_regwrite, w_hz, w_load, w_issue, w_en;
    logic [XLEN-1:0] w_imm, w_op1, w_op2;

    logic            r_ex_valid, r_ex_funct7b5, r_ex_regwrite, r_ex_memread, r_ex_memwrite;
    logic [PC_W-1:0] r_ex_pc;
    logic [XLEN-1:0] r_ex_rs1_data, r_ex_rs2_data, r_ex_imm;
    logic [4:0]      r_ex_rs1, r_ex_rs2, r_ex_rd;
    logic [6:0]      r_ex_opcode;
    logic [2:0]      r_ex_funct3;

    assign w_opcode   = bus.if_instr[6:0];
    assign w_rd       = bus.if_instr[11:7];
    assign w_rs1      = bus.if_instr[19:15];
    assign w_rs2      = bus.if_instr[24:20];
    assign bus.rf_rs1 = w_rs1;
    assign bus.rf_rs2 = w_rs2;

    always_comb begin
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        w_rw_raw   = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        case (w_opcode)
            OPC_OP:              begin w_rs1_used = 1'b1; w_rs2_used = 1'b1; w_rw_raw = 1'b1; end
            OPC_OPIMM, OPC_JALR: begin w_rs1_used = 1'b1; w_rw_raw = 1'b1; end
            OPC_LOAD:            begin w_rs1_used = 1'b1; w_rw_raw = 1'b1; w_memread = 1'b1; end
            OPC_STORE:           begin w_rs1_used = 1'b1; w_rs2_used = 1'b1; w_memwrite = 1'b1; end
            OPC_BRANCH:          begin w_rs1_used = 1'b1; w_rs2_used = 1'b1; end
            OPC_JAL, OPC_LUI, OPC_AUIPC: w_rw_raw = 1'b1;
            default: ;
        endcase
    end

    assign w_regwrite = w_rw_raw & (w_rd != 5'd0);

    imm_gen u_imm_gen (
        .i_instr (bus.if_instr),
        .o_imm   (w_imm)
    );

    // A write landing in the same cycle as the read wins over the stale array value.
    function automatic logic [XLEN-1:0] bypass(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rf_data,
        input logic            wb_we,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        if (idx == 5'd0)
            return '0;
        if (wb_we && (wb_rd == idx))
            return wb_data;
        return rf_data;
    endfunction

    assign w_op1 = bypass(w_rs1, bus.rf_rs1_data, bus.wb_regwrite, bus.wb_rd, bus.wb_data);
    assign w_op2 = bypass(w_rs2, bus.rf_rs2_data, bus.wb_regwrite, bus.wb_rd, bus.wb_data);

    assign w_hz = bus.if_valid & r_ex_valid & r_ex_memread & (r_ex_rd != 5'd0) &
                  ((w_rs1_used & (r_ex_rd == w_rs1)) | (w_rs2_used & (r_ex_rd == w_rs2)));

    // Flush beats stall beats hazard; bubbles are loaded as all-zero entries.
    assign bus.id_ready = bus.flush | (~bus.ex_stall & ~w_hz);
    assign w_load       = ~bus.flush & ~bus.ex_stall & ~w_hz;
    assign w_issue      = w_load & bus.if_valid;
    assign w_en         = bus.flush | ~bus.ex_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_pc       <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_ex_imm      <= '0;
            r_ex_opcode   <= '0;
            r_ex_funct3   <= '0;
            r_ex_funct7b5 <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_memwrite <= 1'b0;
        end else if (w_en) begin
            r_ex_valid    <= w_issue;
            r_ex_pc       <= w_load ? bus.if_pc : '0;
            r_ex_rs1_data <= w_load ? w_op1 : '0;
            r_ex_rs2_data <= w_load ? w_op2 : '0;
            r_ex_rs1      <= w_load ? w_rs1 : '0;
            r_ex_rs2      <= w_load ? w_rs2 : '0;
            r_ex_rd       <= w_load ? w_rd : '0;
            r_ex_imm      <= w_load ? w_imm : '0;
            r_ex_opcode   <= w_load ? w_opcode : '0;
            r_ex_funct3   <= w_load ? bus.if_instr[14:12] : '0;
            r_ex_funct7b5 <= w_load & bus.if_instr[30];
            r_ex_regwrite <= w_issue & w_regwrite;
            r_ex_memread  <= w_issue & w_memread;
            r_ex_memwrite <= w_issue & w_memwrite;
        end
    end

    assign bus.ex_valid    = r_ex_valid;
    assign bus.ex_pc       = r_ex_pc;
    assign bus.ex_rs1_data = r_ex_rs1_data;
    assign bus.ex_rs2_data = r_ex_rs2_data;
    assign bus.ex_rs1      = r_ex_rs1;
    assign bus.ex_rs2      = r_ex_rs2;
    assign bus.ex_rd       = r_ex_rd;
    assign bus.ex_imm      = r_ex_imm;
    assign bus.ex_opcode   = r_ex_opcode;
    assign bus.ex_funct3   = r_ex_funct3;
    assign bus.ex_funct7b5 = r_ex_funct7b5;
    assign bus.ex_regwrite = r_ex_regwrite;
    assign bus.ex_memread  = r_ex_memread;
    assign bus.ex_memwrite = r_ex_memwrite;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: issue, bypass, load-use, flush/stall priority,
// asynchronous reset and immediate formats with hand-computed expectations.
module tb_id_stage;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    id_stage_if #(.XLEN(32), .PC_W(32)) ifc ();

    id_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] I_ADDI_X5   = 32'h00C00293; // addi x5,x0,12
    localparam logic [31:0] I_ADD_6_5_5 = 32'h00528333; // add x6,x5,x5
    localparam logic [31:0] I_ADD_6_0_0 = 32'h00000333; // add x6,x0,x0
    localparam logic [31:0] I_LW_X7     = 32'h0000A383; // lw x7,0(x1)
    localparam logic [31:0] I_ADD_8_7_2 = 32'h00238433; // add x8,x7,x2
    localparam logic [31:0] I_LW_X0     = 32'h0000A003; // lw x0,0(x1)
    localparam logic [31:0] I_ADD_9_0_0 = 32'h000004B3; // add x9,x0,x0
    localparam logic [31:0] I_LUI_X1    = 32'h123450B7; // lui x1,0x12345
    localparam logic [31:0] I_SW_M4     = 32'hFE20AE23; // sw x2,-4(x1)
    localparam logic [31:0] I_BEQ_M8    = 32'hFE208CE3; // beq x1,x2,-8
    localparam logic [31:0] I_JAL_800   = 32'h001000EF; // jal x1,+0x800
    localparam logic [31:0] I_UNKNOWN   = 32'h0000037F; // opcode 0x7F, rd=6

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        ifc.if_valid = v;
        ifc.if_instr = instr;
        ifc.if_pc    = pc;
    endtask

    initial begin
        ifc.rf_rs1_data = '0;
        ifc.rf_rs2_data = '0;
        ifc.wb_regwrite = 1'b0;
        ifc.wb_rd       = '0;
        ifc.wb_data     = '0;
        ifc.ex_stall    = 1'b0;
        ifc.flush       = 1'b0;
        drive(1'b1, I_ADDI_X5, 32'h40);

        // Reset holds even with a valid instruction waiting
        @(negedge clk);
        chk("reset_valid", 32'(ifc.ex_valid), 32'd0);
        chk("reset_pc", ifc.ex_pc, 32'h0);
        chk("reset_imm", ifc.ex_imm, 32'h0);
        chk("rf_rs1_addr", 32'(ifc.rf_rs1), 32'd0);
        rst_n = 1'b1;
        $display("txn reset release");

        @(negedge clk);
        chk("issue_valid", 32'(ifc.ex_valid), 32'd1);
        chk("issue_rd", 32'(ifc.ex_rd), 32'd5);
        chk("issue_imm", ifc.ex_imm, 32'd12);
        chk("issue_regwrite", 32'(ifc.ex_regwrite), 32'd1);
        chk("issue_pc", ifc.ex_pc, 32'h40);
        chk("issue_opcode", 32'(ifc.ex_opcode), 32'h13);
        $display("txn addi x5,x0,12 pc=0x40");

        // Bypass from write-back
        drive(1'b1, I_ADD_6_5_5, 32'h44);
        ifc.wb_regwrite = 1'b1;
        ifc.wb_rd       = 5'd5;
        ifc.wb_data     = 32'hDEADBEEF;
        #1;
        chk("rf_rs1_addr", 32'(ifc.rf_rs1), 32'd5);
        chk("rf_rs2_addr", 32'(ifc.rf_rs2), 32'd5);
        chk("bypass_ready", 32'(ifc.id_ready), 32'd1);
        @(negedge clk);
        chk("bypass_op1", ifc.ex_rs1_data, 32'hDEADBEEF);
        chk("bypass_op2", ifc.ex_rs2_data, 32'hDEADBEEF);
        chk("bypass_rd", 32'(ifc.ex_rd), 32'd6);
        chk("bypass_rs1", 32'(ifc.ex_rs1), 32'd5);
        $display("txn add x6,x5,x5 bypass wb x5");

        // No bypass when wb targets another register
        drive(1'b1, I_ADD_6_5_5, 32'h48);
        ifc.wb_rd       = 5'd7;
        ifc.rf_rs1_data = 32'h11;
        ifc.rf_rs2_data = 32'h22;
        @(negedge clk);
        chk("nobyp_op1", ifc.ex_rs1_data, 32'h11);
        chk("nobyp_op2", ifc.ex_rs2_data, 32'h22);
        $display("txn add x6,x5,x5 wb x7 no bypass");

        // wb_rd = 0 never bypasses
        drive(1'b1, I_ADD_6_5_5, 32'h4C);
        ifc.wb_rd       = 5'd0;
        ifc.rf_rs1_data = 32'h0;
        ifc.rf_rs2_data = 32'h0;
        @(negedge clk);
        chk("wb0_op1", ifc.ex_rs1_data, 32'h0);
        chk("wb0_op2", ifc.ex_rs2_data, 32'h0);
        $display("txn add x6,x5,x5 wb x0");

        // Index 0 reads as zero whatever the array returns
        drive(1'b1, I_ADD_6_0_0, 32'h4E);
        ifc.rf_rs1_data = 32'h55;
        ifc.rf_rs2_data = 32'h66;
        @(negedge clk);
        chk("x0_op1", ifc.ex_rs1_data, 32'h0);
        chk("x0_op2", ifc.ex_rs2_data, 32'h0);
        ifc.wb_regwrite = 1'b0;
        ifc.rf_rs1_data = 32'h0;
        ifc.rf_rs2_data = 32'h0;
        $display("txn add x6,x0,x0");

        // Load-use: one stall cycle, one bubble
        drive(1'b1, I_LW_X7, 32'h50);
        #1 chk("lw_ready", 32'(ifc.id_ready), 32'd1);
        @(negedge clk);
        chk("lw_memread", 32'(ifc.ex_memread), 32'd1);
        chk("lw_rd", 32'(ifc.ex_rd), 32'd7);
        drive(1'b1, I_ADD_8_7_2, 32'h54);
        #1 chk("lu_ready_stall", 32'(ifc.id_ready), 32'd0);
        @(negedge clk);
        chk("lu_bubble_valid", 32'(ifc.ex_valid), 32'd0);
        chk("lu_bubble_memread", 32'(ifc.ex_memread), 32'd0);
        #1 chk("lu_ready_after", 32'(ifc.id_ready), 32'd1);
        @(negedge clk);
        chk("lu_issue_valid", 32'(ifc.ex_valid), 32'd1);
        chk("lu_issue_rd", 32'(ifc.ex_rd), 32'd8);
        chk("lu_issue_pc", ifc.ex_pc, 32'h54);
        $display("txn lw x7 / add x8,x7,x2 load-use");

        // Load to x0 never stalls
        drive(1'b1, I_LW_X0, 32'h58);
        @(negedge clk);
        drive(1'b1, I_ADD_9_0_0, 32'h5C);
        #1 chk("lwx0_ready", 32'(ifc.id_ready), 32'd1);
        @(negedge clk);
        chk("lwx0_valid", 32'(ifc.ex_valid), 32'd1);
        chk("lwx0_rd", 32'(ifc.ex_rd), 32'd9);
        $display("txn lw x0 / add x9,x0,x0");

        // Flush during a load-use stall
        drive(1'b1, I_LW_X7, 32'h60);
        @(negedge clk);
        drive(1'b1, I_ADD_8_7_2, 32'h64);
        #1 chk("fl_hz_ready", 32'(ifc.id_ready), 32'd0);
        ifc.flush = 1'b1;
        #1 chk("fl_ready", 32'(ifc.id_ready), 32'd1);
        @(negedge clk);
        chk("fl_valid", 32'(ifc.ex_valid), 32'd0);
        ifc.flush = 1'b0;
        drive(1'b1, I_ADDI_X5, 32'h68);
        @(negedge clk);
        chk("fl_next_valid", 32'(ifc.ex_valid), 32'd1);
        $display("txn flush during load-use");

        // Flush overrides ex_stall
        drive(1'b1, I_LUI_X1, 32'h6C);
        ifc.ex_stall = 1'b1;
        ifc.flush    = 1'b1;
        #1 chk("flst_ready", 32'(ifc.id_ready), 32'd1);
        @(negedge clk);
        chk("flst_valid", 32'(ifc.ex_valid), 32'd0);
        chk("flst_pc", ifc.ex_pc, 32'h0);
        ifc.ex_stall = 1'b0;
        ifc.flush    = 1'b0;
        $display("txn flush with ex_stall");

        // Three-cycle ex_stall holds ID/EX
        drive(1'b1, I_ADDI_X5, 32'h70);
        @(negedge clk);
        drive(1'b1, I_LUI_X1, 32'h74);
        ifc.ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ready", 32'(ifc.id_ready), 32'd0);
            @(negedge clk);
            chk("stall_valid", 32'(ifc.ex_valid), 32'd1);
            chk("stall_pc", ifc.ex_pc, 32'h70);
            chk("stall_imm", ifc.ex_imm, 32'd12);
            $display("txn ex_stall cycle %0d", i);
        end
        ifc.ex_stall = 1'b0;
        #1 chk("unstall_ready", 32'(ifc.id_ready), 32'd1);
        @(negedge clk);
        chk("lui_pc", ifc.ex_pc, 32'h74);
        chk("lui_imm", ifc.ex_imm, 32'h12345000);
        chk("lui_rd", 32'(ifc.ex_rd), 32'd1);
        $display("txn lui x1,0x12345");

        // Immediate formats
        drive(1'b1, I_SW_M4, 32'h78);
        @(negedge clk);
        chk("sw_imm", ifc.ex_imm, 32'hFFFFFFFC);
        chk("sw_memwrite", 32'(ifc.ex_memwrite), 32'd1);
        chk("sw_regwrite", 32'(ifc.ex_regwrite), 32'd0);
        $display("txn sw offset -4");
        drive(1'b1, I_BEQ_M8, 32'h7C);
        @(negedge clk);
        chk("beq_imm", ifc.ex_imm, 32'hFFFFFFF8);
        chk("beq_regwrite", 32'(ifc.ex_regwrite), 32'd0);
        $display("txn beq offset -8");
        drive(1'b1, I_JAL_800, 32'h80);
        @(negedge clk);
        chk("jal_imm", ifc.ex_imm, 32'h00000800);
        chk("jal_regwrite", 32'(ifc.ex_regwrite), 32'd1);
        $display("txn jal offset +0x800");
        drive(1'b1, I_UNKNOWN, 32'h84);
        @(negedge clk);
        chk("unk_valid", 32'(ifc.ex_valid), 32'd1);
        chk("unk_regwrite", 32'(ifc.ex_regwrite), 32'd0);
        chk("unk_imm", ifc.ex_imm, 32'h0);
        $display("txn unknown opcode");

        // Asynchronous reset during a stall
        drive(1'b1, I_ADDI_X5, 32'h88);
        ifc.ex_stall = 1'b1;
        @(negedge clk);
        chk("prerst_valid", 32'(ifc.ex_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ifc.ex_valid), 32'd0);
        chk("arst_pc", ifc.ex_pc, 32'h0);
        chk("arst_opcode", 32'(ifc.ex_opcode), 32'd0);
        @(negedge clk);
        rst_n        = 1'b1;
        ifc.ex_stall = 1'b0;
        @(negedge clk);
        chk("postrst_valid", 32'(ifc.ex_valid), 32'd1);
        chk("postrst_pc", ifc.ex_pc, 32'h88);
        $display("txn async reset mid-stall");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
